load_store_unit: RTL and testbench

- Memory-stage load/store unit downstream of the instruction decode/control logic.
- Consumes the control decode outputs (mem_read, mem_write, byte mask, funct3) plus the ALU address and rs2 data.
- Runs a ready/valid handshake with a variable-latency data memory, stalls the pipeline until the access completes, and returns aligned, sign/zero-extended load data to writeback.

---
 rtl/load_store_unit.sv | 170 +++++++++++++++++
 tb/tb_load_store_unit.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: ready/valid handshake with a variable-latency data memory,
// lane shifting, load extension and a request timeout. Optional feature macro: LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_funct3,
    input  logic [3:0]  i_dmem_mask,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_store_data,
    output logic        o_dmem_req,
    output logic        o_dmem_wen,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_mask,
    input  logic        i_dmem_ready,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_stall,
    output logic        o_load_valid,
    output logic [31:0] o_load_data,
    output logic        o_misaligned,
    output logic        o_bus_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q;
    logic [29:0] addr_q;
    logic [1:0]  off_q;
    logic [2:0]  funct3_q;
    logic        wen_q;
    logic [31:0] wdata_q;
    logic [3:0]  mask_q;
    logic        err_q;
    logic [31:0] load_data_q;

    logic        mem_op;
    logic        misaligned;
    logic        start;
    logic        timeout;
    logic [1:0]  offset;
    logic [31:0] rshift;
    logic [31:0] load_ext;

    assign mem_op = i_valid & (i_mem_read | i_mem_write);

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        misaligned = 1'b0;
        case (i_funct3[1:0])
            2'b01:        misaligned = i_addr[0];
            2'b10, 2'b11: misaligned = |i_addr[1:0];
            default:      misaligned = 1'b0;
        endcase
    end
    assign offset       = i_addr[1:0];
    assign o_misaligned = (state_q == IDLE) & mem_op & misaligned;
`else
    // Without the trap, the lane offset is snapped to the natural alignment of the access size.
    always_comb begin
        offset = i_addr[1:0];
        case (i_funct3[1:0])
            2'b01:        offset = {i_addr[1], 1'b0};
            2'b10, 2'b11: offset = 2'b00;
            default:      offset = i_addr[1:0];
        endcase
    end
    assign misaligned   = 1'b0;
    assign o_misaligned = 1'b0;
`endif

    assign start   = (state_q == IDLE) & mem_op & ~misaligned;
    assign timeout = (cnt_q == 8'(TIMEOUT_CYCLES - 1));

    always_comb begin
        rshift   = i_dmem_rdata >> {off_q, 3'b000};
        load_ext = rshift;
        case (funct3_q)
            3'b000:  load_ext = {{24{rshift[7]}}, rshift[7:0]};
            3'b100:  load_ext = {24'd0, rshift[7:0]};
            3'b001:  load_ext = {{16{rshift[15]}}, rshift[15:0]};
            3'b101:  load_ext = {16'd0, rshift[15:0]};
            default: load_ext = rshift;
        endcase
    end

    // A handshake arriving in the timeout cycle takes priority over the abort.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = REQ;
            REQ: begin
                if (i_dmem_ready)  state_d = wen_q ? DONE : WAIT;
                else if (timeout)  state_d = DONE;
            end
            WAIT: begin
                if (i_dmem_rvalid) state_d = DONE;
                else if (timeout)  state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            off_q       <= '0;
            funct3_q    <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            mask_q      <= '0;
            err_q       <= 1'b0;
            load_data_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_q   <= i_addr[31:2];
                        off_q    <= offset;
                        funct3_q <= i_funct3;
                        wen_q    <= ~i_mem_read;
                        wdata_q  <= i_store_data << {offset, 3'b000};
                        mask_q   <= i_dmem_mask << offset;
                        cnt_q    <= '0;
                        err_q    <= 1'b0;
                    end
                end
                REQ: begin
                    if (i_dmem_ready) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                        if (timeout) err_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (i_dmem_rvalid) begin
                        load_data_q <= load_ext;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                        if (timeout) err_q <= 1'b1;
                    end
                end
                DONE: err_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign o_dmem_req   = (state_q == REQ);
    assign o_dmem_wen   = wen_q;
    assign o_dmem_addr  = {addr_q, 2'b00};
    assign o_dmem_wdata = wdata_q;
    assign o_dmem_mask  = mask_q;
    assign o_stall      = start | (state_q == REQ) | (state_q == WAIT);
    assign o_load_valid = (state_q == DONE) & ~wen_q & ~err_q;
    assign o_bus_err    = (state_q == DONE) & err_q;
    assign o_load_data  = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with TIMEOUT_CYCLES=4; load results are checked
// through an expected-data queue filled when each load is issued.
module tb_load_store_unit;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic        i_mem_read;
    logic        i_mem_write;
    logic [2:0]  i_funct3;
    logic [3:0]  i_dmem_mask;
    logic [31:0] i_addr;
    logic [31:0] i_store_data;
    logic        o_dmem_req;
    logic        o_dmem_wen;
    logic [31:0] o_dmem_addr;
    logic [31:0] o_dmem_wdata;
    logic [3:0]  o_dmem_mask;
    logic        i_dmem_ready;
    logic        i_dmem_rvalid;
    logic [31:0] i_dmem_rdata;
    logic        o_stall;
    logic        o_load_valid;
    logic [31:0] o_load_data;
    logic        o_misaligned;
    logic        o_bus_err;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_load;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_valid      (i_valid),
        .i_mem_read   (i_mem_read),
        .i_mem_write  (i_mem_write),
        .i_funct3     (i_funct3),
        .i_dmem_mask  (i_dmem_mask),
        .i_addr       (i_addr),
        .i_store_data (i_store_data),
        .o_dmem_req   (o_dmem_req),
        .o_dmem_wen   (o_dmem_wen),
        .o_dmem_addr  (o_dmem_addr),
        .o_dmem_wdata (o_dmem_wdata),
        .o_dmem_mask  (o_dmem_mask),
        .i_dmem_ready (i_dmem_ready),
        .i_dmem_rvalid(i_dmem_rvalid),
        .i_dmem_rdata (i_dmem_rdata),
        .o_stall      (o_stall),
        .o_load_valid (o_load_valid),
        .o_load_data  (o_load_data),
        .o_misaligned (o_misaligned),
        .o_bus_err    (o_bus_err)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        i_valid      = 1'b0;
        i_mem_read   = 1'b0;
        i_mem_write  = 1'b0;
        i_funct3     = 3'b000;
        i_dmem_mask  = 4'b0000;
        i_addr       = '0;
        i_store_data = '0;
        i_dmem_ready = 1'b0;
        i_dmem_rvalid = 1'b0;
        i_dmem_rdata = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " req"},   32'(o_dmem_req), 32'd0);
        check({tag, " wen"},   32'(o_dmem_wen), 32'd0);
        check({tag, " addr"},  o_dmem_addr, 32'd0);
        check({tag, " wdata"}, o_dmem_wdata, 32'd0);
        check({tag, " mask"},  32'(o_dmem_mask), 32'd0);
        check({tag, " stall"}, 32'(o_stall), 32'd0);
        check({tag, " lvalid"}, 32'(o_load_valid), 32'd0);
        check({tag, " ldata"}, o_load_data, 32'd0);
        check({tag, " misal"}, 32'(o_misaligned), 32'd0);
        check({tag, " berr"},  32'(o_bus_err), 32'd0);
    endtask

    // Ends in the DONE cycle, sampled 1 time unit after the falling edge.
    task automatic do_store(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [2:0] f3, input logic [3:0] m, input int unsigned ready_delay,
                            input logic [31:0] exp_addr, input logic [3:0] exp_mask,
                            input logic [31:0] exp_wdata);
        @(negedge i_clk);
        i_valid = 1'b1; i_mem_write = 1'b1; i_mem_read = 1'b0;
        i_funct3 = f3; i_dmem_mask = m; i_addr = addr; i_store_data = data;
        i_dmem_ready = (ready_delay == 0);
        #1 check({tag, " stall_idle"}, 32'(o_stall), 32'd1);
        for (int unsigned k = 0; k <= ready_delay; k++) begin
            @(negedge i_clk);
            i_valid = 1'b0; i_mem_write = 1'b0; i_addr = '1; i_store_data = '1;
            i_dmem_ready = (k == ready_delay);
            #1;
            check({tag, " req"},   32'(o_dmem_req), 32'd1);
            check({tag, " wen"},   32'(o_dmem_wen), 32'd1);
            check({tag, " addr"},  o_dmem_addr, exp_addr);
            check({tag, " mask"},  32'(o_dmem_mask), 32'(exp_mask));
            check({tag, " wdata"}, o_dmem_wdata, exp_wdata);
            check({tag, " stall_req"}, 32'(o_stall), 32'd1);
        end
        @(negedge i_clk);
        i_dmem_ready = 1'b0;
        #1;
        check({tag, " stall_done"}, 32'(o_stall), 32'd0);
        check({tag, " req_done"},   32'(o_dmem_req), 32'd0);
        check({tag, " lvalid"},     32'(o_load_valid), 32'd0);
        check({tag, " berr"},       32'(o_bus_err), 32'd0);
    endtask

    // rvalid arrives in the lat-th WAIT cycle; ends in the DONE cycle.
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [3:0] m, input logic [31:0] rdata, input int unsigned lat,
                           input logic [31:0] exp_data);
        logic [31:0] exp;
        exp_q.push_back(exp_data);
        @(negedge i_clk);
        i_valid = 1'b1; i_mem_read = 1'b1; i_mem_write = 1'b0;
        i_funct3 = f3; i_dmem_mask = m; i_addr = addr; i_dmem_ready = 1'b1;
        #1 check({tag, " stall_idle"}, 32'(o_stall), 32'd1);
        @(negedge i_clk);
        i_valid = 1'b0; i_mem_read = 1'b0; i_addr = '1;
        #1;
        check({tag, " req"},  32'(o_dmem_req), 32'd1);
        check({tag, " wen"},  32'(o_dmem_wen), 32'd0);
        check({tag, " addr"}, o_dmem_addr, {addr[31:2], 2'b00});
        for (int unsigned k = 1; k <= lat; k++) begin
            @(negedge i_clk);
            i_dmem_ready  = 1'b0;
            i_dmem_rvalid = (k == lat);
            i_dmem_rdata  = (k == lat) ? rdata : 32'hA5A5_5A5A;
            #1;
            check({tag, " req_wait"},   32'(o_dmem_req), 32'd0);
            check({tag, " stall_wait"}, 32'(o_stall), 32'd1);
        end
        @(negedge i_clk);
        i_dmem_rvalid = 1'b0; i_dmem_rdata = 32'h5A5A_A5A5;
        #1;
        check({tag, " lvalid"},     32'(o_load_valid), 32'd1);
        check({tag, " stall_done"}, 32'(o_stall), 32'd0);
        check({tag, " berr"},       32'(o_bus_err), 32'd0);
        if (o_load_valid === 1'b1 && exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check({tag, " ldata"}, o_load_data, exp);
            last_load = exp;
        end else begin
            exp = exp_q.pop_front();
            last_load = exp;
        end
    endtask

    initial begin
        idle_inputs();
        i_rst_n = 1'b0;
        last_load = '0;
        repeat (2) @(negedge i_clk);
        #1 check_all_zero("reset");
        i_rst_n = 1'b1;

        do_store("sw",   32'h100, 32'hDEAD_BEEF, 3'b010, 4'b1111, 0, 32'h100, 4'b1111, 32'hDEAD_BEEF);
        do_store("sb",   32'h103, 32'h0000_00A5, 3'b000, 4'b0001, 0, 32'h100, 4'b1000, 32'hA500_0000);
        do_store("sh",   32'h206, 32'hCAFE_1234, 3'b001, 4'b0011, 2, 32'h204, 4'b1100, 32'h1234_0000);
        do_store("sw_rdy_at_to", 32'h30C, 32'h0BAD_F00D, 3'b010, 4'b1111, 3, 32'h30C, 4'b1111, 32'h0BAD_F00D);

        do_load("lb",  32'h102, 3'b000, 4'b0001, 32'h0080_FF00, 3, 32'hFFFF_FF80);
        @(negedge i_clk);
        #1;
        check("lb hold lvalid", 32'(o_load_valid), 32'd0);
        check("lb hold ldata",  o_load_data, 32'hFFFF_FF80);
        do_load("lbu", 32'h102, 3'b100, 4'b0001, 32'h0080_FF00, 3, 32'h0000_0080);
        do_load("lh",  32'h102, 3'b001, 4'b0011, 32'h8001_FFFF, 1, 32'hFFFF_8001);
        do_load("lhu", 32'h102, 3'b101, 4'b0011, 32'h8001_FFFF, 2, 32'h0000_8001);
        do_load("lb_pos", 32'h101, 3'b000, 4'b0001, 32'h0000_7F00, 1, 32'h0000_007F);
        do_load("lw_rv_at_to", 32'h400, 3'b010, 4'b1111, 32'h1234_5678, 4, 32'h1234_5678);

        // Op offered during DONE must wait for the following IDLE cycle.
        do_store("sw_b2b", 32'h500, 32'h1111_2222, 3'b010, 4'b1111, 0, 32'h500, 4'b1111, 32'h1111_2222);
        i_valid = 1'b1; i_mem_read = 1'b1; i_funct3 = 3'b010; i_dmem_mask = 4'b1111; i_addr = 32'h504;
        #1;
        check("done_op stall", 32'(o_stall), 32'd0);
        check("done_op req",   32'(o_dmem_req), 32'd0);
        do_load("lw_b2b", 32'h504, 3'b010, 4'b1111, 32'hCAFE_BABE, 1, 32'hCAFE_BABE);

        // Timeout with ready never asserted.
        @(negedge i_clk);
        i_valid = 1'b1; i_mem_read = 1'b1; i_funct3 = 3'b010; i_addr = 32'h600; i_dmem_ready = 1'b0;
        #1 check("to stall_idle", 32'(o_stall), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            i_valid = 1'b0; i_mem_read = 1'b0;
            #1;
            check("to req",   32'(o_dmem_req), 32'd1);
            check("to berr0", 32'(o_bus_err), 32'd0);
        end
        @(negedge i_clk);
        #1;
        check("to berr",   32'(o_bus_err), 32'd1);
        check("to stall",  32'(o_stall), 32'd0);
        check("to req_off", 32'(o_dmem_req), 32'd0);
        check("to lvalid", 32'(o_load_valid), 32'd0);
        check("to ldata",  o_load_data, last_load);
        @(negedge i_clk);
        #1 check("to berr_pulse", 32'(o_bus_err), 32'd0);

        // Timeout while waiting for rvalid.
        i_valid = 1'b1; i_mem_read = 1'b1; i_funct3 = 3'b010; i_addr = 32'h700; i_dmem_ready = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0; i_mem_read = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            i_dmem_ready = 1'b0;
            #1 check("wto stall", 32'(o_stall), 32'd1);
        end
        @(negedge i_clk);
        #1;
        check("wto berr",   32'(o_bus_err), 32'd1);
        check("wto lvalid", 32'(o_load_valid), 32'd0);

        // Reset in WAIT drops the access; a late rvalid is ignored.
        @(negedge i_clk);
        i_valid = 1'b1; i_mem_read = 1'b1; i_funct3 = 3'b010; i_addr = 32'h800; i_dmem_ready = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0; i_mem_read = 1'b0;
        @(negedge i_clk);
        i_dmem_ready = 1'b0;
        #1 check("rst wait stall", 32'(o_stall), 32'd1);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1; i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h7777_7777;
        #1 check_all_zero("rst_wait");
        @(negedge i_clk);
        i_dmem_rvalid = 1'b0;
        #1 check_all_zero("rst_after");

`ifdef LSU_MISALIGN_TRAP_EN
        @(negedge i_clk);
        i_valid = 1'b1; i_mem_read = 1'b1; i_funct3 = 3'b010; i_dmem_mask = 4'b1111; i_addr = 32'h102;
        #1;
        check("lw_mis misal", 32'(o_misaligned), 32'd1);
        check("lw_mis req",   32'(o_dmem_req), 32'd0);
        check("lw_mis stall", 32'(o_stall), 32'd0);
        @(negedge i_clk);
        i_mem_read = 1'b0; i_mem_write = 1'b1; i_funct3 = 3'b001; i_dmem_mask = 4'b0011; i_addr = 32'h103;
        #1;
        check("sh_mis misal", 32'(o_misaligned), 32'd1);
        check("sh_mis req",   32'(o_dmem_req), 32'd0);
        check("sh_mis stall", 32'(o_stall), 32'd0);
        @(negedge i_clk);
        idle_inputs();
        #1 check("mis clear", 32'(o_misaligned), 32'd0);
        do_load("lh_al", 32'h102, 3'b001, 4'b0011, 32'h8001_FFFF, 1, 32'hFFFF_8001);
`else
        do_store("sw_unal", 32'h102, 32'h89AB_CDEF, 3'b010, 4'b1111, 0, 32'h100, 4'b1111, 32'h89AB_CDEF);
        check("sw_unal misal", 32'(o_misaligned), 32'd0);
        do_store("sh_unal", 32'h103, 32'h0000_BEEF, 3'b001, 4'b0011, 0, 32'h100, 4'b1100, 32'hBEEF_0000);
        do_load("lw_unal", 32'h103, 3'b010, 4'b1111, 32'h1122_3344, 1, 32'h1122_3344);
`endif

        @(negedge i_clk);
        idle_inputs();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
